// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS core: ALU operations, mux selects
// and instruction field positions used by datapath, controller and benches.
package mips_pkg;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUSRCB_REG   = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
    localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALURES  = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT  = 2'b01;
    localparam logic [1:0] PCSRC_JUMP    = 2'b10;
    localparam logic [1:0] PCSRC_ALURES2 = 2'b11;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int IMM_MSB    = 15;
    localparam int FUNCT_MSB  = 5;
    localparam int JADDR_MSB  = 25;

endpackage

// File: rtl/mips_regfile.sv
// 32x32 register file with two combinational read ports and one synchronous
// write port; register 0 is hardwired to zero.
module mips_regfile (
    input  logic        i_clk,
    input  logic        i_we,
    input  logic [4:0]  i_ra1,
    input  logic [4:0]  i_ra2,
    input  logic [4:0]  i_wa,
    input  logic [31:0] i_wd,
    output logic [31:0] o_rd1,
    output logic [31:0] o_rd2
);

    logic [31:0] r_regs [32];

    always_ff @(posedge i_clk) begin
        if (i_we && (i_wa != 5'd0)) begin
            r_regs[i_wa] <= i_wd;
        end
    end

    assign o_rd1 = (i_ra1 == 5'd0) ? 32'd0 : r_regs[i_ra1];
    assign o_rd2 = (i_ra2 == 5'd0) ? 32'd0 : r_regs[i_ra2];

endmodule

// File: rtl/mips_multicycle_datapath.sv
// Datapath half of the multicycle MIPS core: architectural registers, ALU,
// operand/PC/address muxes and the register file, steered by controller strobes.
module mips_multicycle_datapath
    import mips_pkg::*;
#(
    parameter int                 WIDTH    = 32,
    parameter logic [WIDTH-1:0]   RESET_PC = '0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_pcen,
    input  logic             i_irwrite,
    input  logic             i_regwrite,
    input  logic             i_alusrca,
    input  logic             i_iord,
    input  logic             i_memtoreg,
    input  logic             i_regdst,
    input  logic [1:0]       i_alusrcb,
    input  logic [1:0]       i_pcsrc,
    input  logic [2:0]       i_alucontrol,
    input  logic [WIDTH-1:0] i_readdata,
    output logic [5:0]       o_opcode,
    output logic [5:0]       o_funct,
    output logic             o_zero,
    output logic [WIDTH-1:0] o_adr,
    output logic [WIDTH-1:0] o_writedata
);

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_instr;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_aluout;

    logic [WIDTH-1:0] w_signimm;
    logic [WIDTH-1:0] w_srca;
    logic [WIDTH-1:0] w_srcb;
    logic [WIDTH-1:0] w_aluresult;
    logic [WIDTH-1:0] w_pcnext;
    logic [WIDTH-1:0] w_rd1;
    logic [WIDTH-1:0] w_rd2;
    logic [WIDTH-1:0] w_wd;
    logic [4:0]       w_wa;
    logic             w_rf_we;

    assign w_signimm = {{(WIDTH-16){r_instr[IMM_MSB]}}, r_instr[IMM_MSB:0]};
    assign w_srca    = i_alusrca ? r_a : r_pc;

    always_comb begin
        w_srcb = r_b;
        case (i_alusrcb)
            ALUSRCB_REG:   w_srcb = r_b;
            ALUSRCB_FOUR:  w_srcb = WIDTH'(4);
            ALUSRCB_IMM:   w_srcb = w_signimm;
            ALUSRCB_IMMSH: w_srcb = {w_signimm[WIDTH-3:0], 2'b00};
            default:       w_srcb = r_b;
        endcase
    end

    // Unused ALU codes deliberately yield zero so the controller sees zero=1.
    always_comb begin
        w_aluresult = '0;
        case (i_alucontrol)
            ALU_ADD: w_aluresult = w_srca + w_srcb;
            ALU_SUB: w_aluresult = w_srca - w_srcb;
            ALU_AND: w_aluresult = w_srca & w_srcb;
            ALU_OR:  w_aluresult = w_srca | w_srcb;
            ALU_SLT: w_aluresult = {{(WIDTH-1){1'b0}}, ($signed(w_srca) < $signed(w_srcb))};
            default: w_aluresult = '0;
        endcase
    end

    always_comb begin
        w_pcnext = w_aluresult;
        case (i_pcsrc)
            PCSRC_ALURES:  w_pcnext = w_aluresult;
            PCSRC_ALUOUT:  w_pcnext = r_aluout;
            PCSRC_JUMP:    w_pcnext = {r_pc[WIDTH-1:WIDTH-4], r_instr[JADDR_MSB:0], 2'b00};
            PCSRC_ALURES2: w_pcnext = w_aluresult;
            default:       w_pcnext = w_aluresult;
        endcase
    end

    // A reset edge must not commit a pending register write.
    assign w_rf_we = i_regwrite & i_reset;
    assign w_wa    = i_regdst ? r_instr[RD_MSB:RD_LSB] : r_instr[RT_MSB:RT_LSB];
    assign w_wd    = i_memtoreg ? r_data : r_aluout;

    mips_regfile u_regfile (
        .i_clk (i_clk),
        .i_we  (w_rf_we),
        .i_ra1 (r_instr[RS_MSB:RS_LSB]),
        .i_ra2 (r_instr[RT_MSB:RT_LSB]),
        .i_wa  (w_wa),
        .i_wd  (w_wd),
        .o_rd1 (w_rd1),
        .o_rd2 (w_rd2)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_pc     <= RESET_PC;
            r_instr  <= '0;
            r_data   <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_aluout <= '0;
        end else begin
            if (i_pcen) begin
                r_pc <= w_pcnext;
            end
            if (i_irwrite) begin
                r_instr <= i_readdata;
            end
            r_data   <= i_readdata;
            r_a      <= w_rd1;
            r_b      <= w_rd2;
            r_aluout <= w_aluresult;
        end
    end

    // Outputs show reset values for the whole reset period, not only after the edge.
    assign o_opcode    = i_reset ? r_instr[OPCODE_MSB:OPCODE_LSB] : 6'd0;
    assign o_funct     = i_reset ? r_instr[FUNCT_MSB:0] : 6'd0;
    assign o_writedata = i_reset ? r_b : '0;
    assign o_adr       = i_reset ? (i_iord ? r_aluout : r_pc) : (i_iord ? '0 : RESET_PC);
    assign o_zero      = (w_aluresult == '0);

endmodule

// File: tb/tb_mips_multicycle_datapath.sv
// Self-checking bench for mips_multicycle_datapath: directed scenarios plus
// randomized strobes, compared against a cycle-level behavioural model.
module tb_mips_multicycle_datapath;
    import mips_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        pcen;
    logic        irwrite;
    logic        regwrite;
    logic        alusrca;
    logic        iord;
    logic        memtoreg;
    logic        regdst;
    logic [1:0]  alusrcb;
    logic [1:0]  pcsrc;
    logic [2:0]  alucontrol;
    logic [31:0] readdata;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic [31:0] adr;
    logic [31:0] writedata;

    int checkCount = 0;
    int passCount  = 0;
    bit checksOn   = 1'b0;

    logic [31:0] mRegs [32];
    logic [31:0] mPc, mInstr, mData, mA, mB, mAluOut;

    always #5 clk = ~clk;

    mips_multicycle_datapath #(
        .WIDTH    (32),
        .RESET_PC (RESET_PC)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_pcen       (pcen),
        .i_irwrite    (irwrite),
        .i_regwrite   (regwrite),
        .i_alusrca    (alusrca),
        .i_iord       (iord),
        .i_memtoreg   (memtoreg),
        .i_regdst     (regdst),
        .i_alusrcb    (alusrcb),
        .i_pcsrc      (pcsrc),
        .i_alucontrol (alucontrol),
        .i_readdata   (readdata),
        .o_opcode     (opcode),
        .o_funct      (funct),
        .o_zero       (zero),
        .o_adr        (adr),
        .o_writedata  (writedata)
    );

    function automatic logic [31:0] aluRef(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] ctl);
        if (ctl == 3'b010) return a + b;
        if (ctl == 3'b110) return a - b;
        if (ctl == 3'b000) return a & b;
        if (ctl == 3'b001) return a | b;
        if (ctl == 3'b111) return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        return 32'd0;
    endfunction

    function automatic logic [31:0] regRead(input logic [31:0] idx);
        return (idx == 0) ? 32'd0 : mRegs[idx];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected)
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        else
            passCount++;
    endtask

    task automatic idle();
        reset = 1'b1; pcen = 1'b0; irwrite = 1'b0; regwrite = 1'b0;
        alusrca = 1'b0; iord = 1'b0; memtoreg = 1'b0; regdst = 1'b0;
        alusrcb = 2'b01; pcsrc = 2'b00; alucontrol = 3'b010; readdata = 32'd0;
    endtask

    // One clock: compare outputs to the model, then advance the model with the DUT.
    task automatic applyStimulus();
        logic [31:0] imm, srcA, srcB, res, target;
        logic [31:0] nPc, nInstr, nA, nB, wIdx, wVal;
        logic        doWrite;
        #2;
        imm  = mInstr[15] ? (32'hFFFF_0000 | (mInstr & 32'hFFFF)) : (mInstr & 32'hFFFF);
        srcA = alusrca ? mA : mPc;
        if (alusrcb == 2'd0)      srcB = mB;
        else if (alusrcb == 2'd1) srcB = 32'd4;
        else if (alusrcb == 2'd2) srcB = imm;
        else                      srcB = imm * 4;
        res = aluRef(srcA, srcB, alucontrol);
        if (checksOn) begin
            checkOutput("zero", 32'(zero), (res == 0) ? 32'd1 : 32'd0);
            if (reset) begin
                checkOutput("opcode", 32'(opcode), mInstr >> 26);
                checkOutput("funct", 32'(funct), mInstr % 64);
                checkOutput("adr", adr, iord ? mAluOut : mPc);
                checkOutput("writedata", writedata, mB);
            end else begin
                checkOutput("rstOpcode", 32'(opcode), 32'd0);
                checkOutput("rstFunct", 32'(funct), 32'd0);
                checkOutput("rstAdr", adr, iord ? 32'd0 : RESET_PC);
                checkOutput("rstWritedata", writedata, 32'd0);
            end
        end
        target  = (mPc & 32'hF000_0000) | ((mInstr % 32'h0400_0000) * 4);
        nPc     = !pcen ? mPc : (pcsrc == 2'd1) ? mAluOut : (pcsrc == 2'd2) ? target : res;
        nInstr  = irwrite ? readdata : mInstr;
        nA      = regRead((mInstr >> 21) % 32);
        nB      = regRead((mInstr >> 16) % 32);
        wIdx    = regdst ? (mInstr >> 11) % 32 : (mInstr >> 16) % 32;
        wVal    = memtoreg ? mData : mAluOut;
        doWrite = reset && regwrite && (wIdx != 0);
        @(posedge clk);
        if (!reset) begin
            mPc = RESET_PC; mInstr = 0; mData = 0; mA = 0; mB = 0; mAluOut = 0;
        end else begin
            if (doWrite) mRegs[wIdx] = wVal;
            mPc = nPc; mInstr = nInstr; mData = readdata; mA = nA; mB = nB; mAluOut = res;
        end
        @(negedge clk);
    endtask

    task automatic loadInstr(input logic [31:0] word);
        idle(); irwrite = 1'b1; readdata = word; applyStimulus(); idle();
    endtask

    task automatic writeReg(input logic [4:0] n, input logic [31:0] value);
        loadInstr({6'h23, 5'd0, n, 16'h0000});
        readdata = value; applyStimulus();
        idle(); regwrite = 1'b1; memtoreg = 1'b1; regdst = 1'b0; applyStimulus();
        idle();
    endtask

    task automatic setPc(input logic [31:0] value);
        writeReg(5'd30, value);
        loadInstr({6'h00, 5'd30, 5'd0, 16'h0000});
        applyStimulus();
        alusrca = 1'b1; alusrcb = 2'b00; alucontrol = 3'b010; pcsrc = 2'b00; pcen = 1'b1;
        applyStimulus();
        idle();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mRegs[i] = 32'd0;
        mPc = 0; mInstr = 0; mData = 0; mA = 0; mB = 0; mAluOut = 0;
        idle(); reset = 1'b0;
        applyStimulus();
        idle();
        for (int i = 1; i < 32; i++) writeReg(5'(i), $urandom);
        applyStimulus();
        checksOn = 1'b1;

        $display("[TB] reset and hold");
        reset = 1'b0; pcen = 1'b1;
        applyStimulus(); applyStimulus();
        #1;
        checkOutput("rstAdrZero", adr, 32'd0);
        checkOutput("rstOpcodeZero", 32'(opcode), 32'd0);
        idle();
        applyStimulus();
        #1 checkOutput("pcHold", adr, 32'd0);

        $display("[TB] lw fetch/execute");
        readdata = 32'h8C02_0004; irwrite = 1'b1; pcen = 1'b1;
        applyStimulus();
        idle();
        #1;
        checkOutput("fetchPc", adr, 32'd4);
        checkOutput("fetchOpcode", 32'(opcode), 32'h23);
        alusrca = 1'b1; alusrcb = 2'b10;
        applyStimulus();
        idle(); iord = 1'b1;
        #1 checkOutput("lwAdr", adr, 32'd4);
        readdata = 32'h1234_5678;
        applyStimulus();
        idle(); regwrite = 1'b1; memtoreg = 1'b1;
        applyStimulus();
        idle();
        applyStimulus();
        #1 checkOutput("lwResult", writedata, 32'h1234_5678);

        $display("[TB] R-type sub/slt");
        writeReg(5'd2, 32'd7);
        writeReg(5'd3, 32'd5);
        loadInstr(32'h0043_2022);
        applyStimulus();
        alusrca = 1'b1; alusrcb = 2'b00; alucontrol = 3'b110; regdst = 1'b1;
        #1;
        checkOutput("subZero", 32'(zero), 32'd0);
        checkOutput("subFunct", 32'(funct), 32'h22);
        applyStimulus();
        regwrite = 1'b1;
        applyStimulus();
        regwrite = 1'b0; iord = 1'b1;
        #1 checkOutput("subAluOut", adr, 32'd2);
        alucontrol = 3'b111;
        #1 checkOutput("sltFalseZero", 32'(zero), 32'd1);
        loadInstr(32'h0062_2022);
        applyStimulus();
        alusrca = 1'b1; alusrcb = 2'b00; alucontrol = 3'b111;
        #1 checkOutput("sltTrueZero", 32'(zero), 32'd0);
        applyStimulus();
        iord = 1'b1;
        #1 checkOutput("sltTrueResult", adr, 32'd1);
        loadInstr(32'h0004_0000);
        applyStimulus();
        #1 checkOutput("reg4", writedata, 32'd2);

        $display("[TB] beq taken");
        setPc(32'd8);
        loadInstr(32'h1042_0003);
        alusrcb = 2'b11;
        applyStimulus();
        idle(); iord = 1'b1;
        #1 checkOutput("beqTarget", adr, 32'd20);
        iord = 1'b0; alusrca = 1'b1; alusrcb = 2'b00; alucontrol = 3'b110;
        pcsrc = 2'b01; pcen = 1'b1;
        #1 checkOutput("beqZero", 32'(zero), 32'd1);
        applyStimulus();
        idle();
        #1 checkOutput("beqPc", adr, 32'd20);

        $display("[TB] jump");
        setPc(32'h4000_0010);
        loadInstr(32'h0800_0100);
        pcsrc = 2'b10; pcen = 1'b1;
        applyStimulus();
        idle();
        #1 checkOutput("jumpPc", adr, 32'h4000_0400);

        $display("[TB] r0, write/read hazard, reset during write");
        writeReg(5'd0, 32'hFFFF_FFFF);
        applyStimulus();
        #1 checkOutput("r0", writedata, 32'd0);
        writeReg(5'd5, 32'h1111_1111);
        loadInstr(32'h00A5_0000);
        readdata = 32'h2222_2222;
        applyStimulus();
        idle(); regwrite = 1'b1; memtoreg = 1'b1;
        applyStimulus();
        idle();
        #1 checkOutput("hazardOld", writedata, 32'h1111_1111);
        applyStimulus();
        #1 checkOutput("hazardNew", writedata, 32'h2222_2222);
        writeReg(5'd6, 32'h3333_3333);
        loadInstr(32'h0006_0000);
        readdata = 32'h4444_4444;
        applyStimulus();
        idle(); reset = 1'b0; regwrite = 1'b1; memtoreg = 1'b1; pcen = 1'b1;
        applyStimulus();
        idle();
        #1 checkOutput("rstWritePc", adr, RESET_PC);
        loadInstr(32'h0006_0000);
        applyStimulus();
        #1 checkOutput("rstWriteReg6", writedata, 32'h3333_3333);

        $display("[TB] random strobes");
        for (int i = 0; i < 400; i++) begin
            reset      = ($urandom_range(0, 31) != 0);
            pcen       = 1'($urandom_range(0, 1));
            irwrite    = 1'($urandom_range(0, 1));
            regwrite   = 1'($urandom_range(0, 1));
            alusrca    = 1'($urandom_range(0, 1));
            iord       = 1'($urandom_range(0, 1));
            memtoreg   = 1'($urandom_range(0, 1));
            regdst     = 1'($urandom_range(0, 1));
            alusrcb    = 2'($urandom_range(0, 3));
            pcsrc      = 2'($urandom_range(0, 3));
            alucontrol = 3'($urandom_range(0, 7));
            readdata   = $urandom;
            applyStimulus();
        end

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
